// File: rtl/witness_pkg.sv
// Shared frame layout, flag positions and loader state encoding for the
// witness step loader.
package witness_pkg;

  localparam int FRAME_WORDS = 8;
  localparam int WORD_W      = 32;

  localparam logic [2:0] W_INSTR0     = 3'd0;
  localparam logic [2:0] W_INSTR1     = 3'd1;
  localparam logic [2:0] W_INSTR2     = 3'd2;
  localparam logic [2:0] W_FLAGS      = 3'd3;
  localparam logic [2:0] W_HINT1_ADDR = 3'd4;
  localparam logic [2:0] W_HINT1_DATA = 3'd5;
  localparam logic [2:0] W_HINT2_ADDR = 3'd6;
  localparam logic [2:0] W_HINT2_DATA = 3'd7;

  localparam int FLAG_HINT1_WR = 0;
  localparam int FLAG_HINT2_WR = 1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  // Bits above the two hint-direction flags must be zero in a well-formed frame.
  function automatic logic reserved_flags_set(input logic [WORD_W-1:0] flags);
    return |flags[WORD_W-1:2];
  endfunction

endpackage

// File: rtl/witness_frame_buffer.sv
// Eight-slot word array with a wrapping write counter; each write lands in
// the slot named by the counter and advances it.
module witness_frame_buffer
  import witness_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [WORD_W-1:0]                   wr_data,
  output logic [2:0]                          count,
  output logic [FRAME_WORDS-1:0][WORD_W-1:0]  slots
);

  // Slot write and counter advance; the 3-bit counter wraps 7 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 3'd0;
      slots <= '0;
    end else if (wr_en) begin
      slots[count] <= wr_data;
      count        <= count + 3'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/witness_step_loader.sv
// Assembles 8-word witness frames into decoder steps, with the frame buffer
// acting as a one-step skid stage behind the registered output.
module witness_step_loader #(
  parameter int FRAME_WORDS  = 8,
  parameter bit STRICT_FLAGS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        step_valid,
  input  logic        step_ready,
  output logic [95:0] raw_instr,
  output logic        hint1_is_write,
  output logic        hint2_is_write,
  output logic [31:0] hint1_address,
  output logic [31:0] hint1_data,
  output logic [31:0] hint2_address,
  output logic [31:0] hint2_data,
  output logic [31:0] step_index,
  output logic        frame_error
);
  import witness_pkg::*;

  localparam logic [2:0] LAST_SLOT = 3'(FRAME_WORDS - 1);

  state_t                               state_r;
  state_t                               state_nxt_s;
  logic [2:0]                           count_s;
  logic [FRAME_WORDS-1:0][31:0]         slots_s;
  logic                                 accept_s;
  logic                                 last_accept_s;
  logic                                 out_free_s;
  logic                                 load_s;
  logic                                 flag_err_s;
  logic [31:0]                          last_word_s;
  logic [31:0]                          step_count_r;
  logic                                 unused_flag_bits_s;

  assign in_ready           = (state_r == COLLECT) && !rst;
  assign accept_s           = in_valid && in_ready;
  assign last_accept_s      = accept_s && (count_s == LAST_SLOT);
  assign out_free_s         = !step_valid || step_ready;
  assign flag_err_s         = STRICT_FLAGS && accept_s && (count_s == W_FLAGS)
                              && reserved_flags_set(in_data);
  assign unused_flag_bits_s = ^slots_s[W_FLAGS][31:2];

  witness_frame_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_s),
    .wr_data (in_data),
    .count   (count_s),
    .slots   (slots_s)
  );

  // The final word bypasses the buffer while collecting so a free output loads with no bubble.
  always_comb begin
    last_word_s = slots_s[LAST_SLOT];
    if (state_r == COLLECT) begin
      last_word_s = in_data;
    end else begin
      last_word_s = slots_s[LAST_SLOT];
    end
  end

  // Next-state and load decision.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      COLLECT: begin
        if (last_accept_s && out_free_s) begin
          load_s = 1'b1;
        end else if (last_accept_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      FULL: begin
        if (step_ready) begin
          load_s      = 1'b1;
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = COLLECT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output step register and running step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_valid     <= 1'b0;
      raw_instr      <= 96'd0;
      hint1_is_write <= 1'b0;
      hint2_is_write <= 1'b0;
      hint1_address  <= 32'd0;
      hint1_data     <= 32'd0;
      hint2_address  <= 32'd0;
      hint2_data     <= 32'd0;
      step_index     <= 32'd0;
      step_count_r   <= 32'd0;
    end else if (load_s) begin
      step_valid     <= 1'b1;
      raw_instr      <= {slots_s[W_INSTR2], slots_s[W_INSTR1], slots_s[W_INSTR0]};
      hint1_is_write <= slots_s[W_FLAGS][FLAG_HINT1_WR];
      hint2_is_write <= slots_s[W_FLAGS][FLAG_HINT2_WR];
      hint1_address  <= slots_s[W_HINT1_ADDR];
      hint1_data     <= slots_s[W_HINT1_DATA];
      hint2_address  <= slots_s[W_HINT2_ADDR];
      hint2_data     <= last_word_s;
      step_index     <= step_count_r;
      step_count_r   <= step_count_r + 32'd1;
    end else if (step_ready) begin
      step_valid <= 1'b0;
    end else begin
      step_valid <= step_valid;
    end
  end

  // Sticky malformed-frame flag; the offending frame is still delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_error <= 1'b0;
    end else if (flag_err_s) begin
      frame_error <= 1'b1;
    end else begin
      frame_error <= frame_error;
    end
  end

endmodule

// File: tb/tb_witness_step_loader.sv
// Bench for witness_step_loader: a queue-of-frames model predicts every
// output each cycle, with directed frames pinning literal values.
module tb_witness_step_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        step_valid;
  logic        step_ready;
  logic [95:0] raw_instr;
  logic        hint1_is_write, hint2_is_write;
  logic [31:0] hint1_address, hint1_data, hint2_address, hint2_data;
  logic [31:0] step_index;
  logic        frame_error;

  witness_step_loader #(.FRAME_WORDS(8), .STRICT_FLAGS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .step_valid(step_valid), .step_ready(step_ready), .raw_instr(raw_instr),
    .hint1_is_write(hint1_is_write), .hint2_is_write(hint2_is_write),
    .hint1_address(hint1_address), .hint1_data(hint1_data),
    .hint2_address(hint2_address), .hint2_data(hint2_data),
    .step_index(step_index), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [95:0] raw;
    logic        h1w, h2w;
    logic [31:0] h1a, h1d, h2a, h2d, idx;
  } step_t;

  step_t       fq[$];
  logic [31:0] cur[$];
  logic [31:0] m_idx = 32'd0;
  logic        m_err = 1'b0;
  logic        m_rdy;
  int          cons_cyc[$];
  logic [31:0] cons_idx[$];
  logic [95:0] cons_raw[$];
  bit          chk_en = 1'b0;
  bit          rand_ready = 1'b0;
  int          preload_cnt = 0;
  int          preload_seen = 0;
  logic [31:0] preload_val = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, got, exp, $time);
    end
  endfunction

  // Model: outstanding frames = delivered-but-unconsumed; output occupied iff >=1, input stalls at 2.
  always @(negedge clk) begin
    step_t s;
    if (preload_cnt != preload_seen) begin
      preload_seen = preload_cnt;
      m_idx = preload_val;
    end
    m_rdy = !rst && (fq.size() < 2);
    if (chk_en) begin
      check("in_ready", in_ready, m_rdy);
      check("step_valid", step_valid, fq.size() > 0);
      check("frame_error", frame_error, m_err);
      if (fq.size() > 0) begin
        check("raw_instr", raw_instr, fq[0].raw);
        check("hint1_is_write", hint1_is_write, fq[0].h1w);
        check("hint2_is_write", hint2_is_write, fq[0].h2w);
        check("hint1_address", hint1_address, fq[0].h1a);
        check("hint1_data", hint1_data, fq[0].h1d);
        check("hint2_address", hint2_address, fq[0].h2a);
        check("hint2_data", hint2_data, fq[0].h2d);
        check("step_index", step_index, fq[0].idx);
      end
    end
    if (rst) begin
      fq.delete();
      cur.delete();
      m_idx = 32'd0;
      m_err = 1'b0;
    end else begin
      if (fq.size() > 0 && step_ready) begin
        cons_cyc.push_back(cyc);
        cons_idx.push_back(step_index);
        cons_raw.push_back(raw_instr);
        void'(fq.pop_front());
      end
      if (in_valid && m_rdy) begin
        if (cur.size() == 3 && in_data[31:2] != 30'd0) m_err = 1'b1;
        cur.push_back(in_data);
        if (cur.size() == 8) begin
          s.raw = {cur[2], cur[1], cur[0]};
          s.h1w = cur[3][0];
          s.h2w = cur[3][1];
          s.h1a = cur[4];
          s.h1d = cur[5];
          s.h2a = cur[6];
          s.h2d = cur[7];
          s.idx = m_idx;
          fq.push_back(s);
          m_idx = m_idx + 32'd1;
          cur.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) step_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int  t;
    logic r;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) break;
      t++;
      if (t > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: word %0h not accepted within 200 cycles", w);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0][31:0] f, input bit gaps);
    for (int i = 0; i < 8; i++) send_word(f[i], gaps);
  endtask

  function automatic logic [7:0][31:0] mk_frame(input logic [31:0] flags);
    logic [7:0][31:0] f;
    for (int i = 0; i < 8; i++) f[i] = $urandom;
    f[3] = flags;
    return f;
  endfunction

  task automatic drain();
    int t;
    step_ready = 1'b1;
    t = 0;
    while (fq.size() > 0 && t < 100) begin
      tick();
      t++;
    end
    if (fq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d steps still pending", fq.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    cons_cyc.delete();
    cons_idx.delete();
    cons_raw.delete();
  endtask

  initial begin
    logic [7:0][31:0] f;
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][31:0] f;
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; step_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_raw_instr", raw_instr, 96'd0);
    check("rst_hints", {hint1_is_write, hint2_is_write, hint1_address, hint1_data, hint2_address, hint2_data}, 130'd0);
    check("rst_step_index", step_index, 32'd0);
    check("rst_step_valid", step_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single frame, latency and field placement
    step_ready = 1'b1;
    f[0] = 32'h11223344; f[1] = 32'h55667788; f[2] = 32'h99AABBCC; f[3] = 32'h00000003;
    f[4] = 32'h00001000; f[5] = 32'h0000DEAD; f[6] = 32'h00002000; f[7] = 32'h0000BEEF;
    send_frame(f, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("single_latency_valid", step_valid, 1'b1);
    check("single_raw", raw_instr, 96'h99AABBCC_55667788_11223344);
    check("single_is_write", {hint1_is_write, hint2_is_write}, 2'b11);
    check("single_hints", {hint1_address, hint1_data, hint2_address, hint2_data},
          128'h00001000_0000DEAD_00002000_0000BEEF);
    check("single_index", step_index, 32'd0);
    drain();

    // backpressure: two frames with the decoder stalled
    do_reset();
    step_ready = 1'b0;
    send_frame(mk_frame(32'd1), 1'b0);
    send_frame(mk_frame(32'd2), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_hold_index", step_index, 32'd0);
    repeat (4) tick();
    drain();
    check("bp_count", cons_idx.size(), 2);
    if (cons_idx.size() == 2) begin
      check("bp_idx0", cons_idx[0], 32'd0);
      check("bp_idx1", cons_idx[1], 32'd1);
    end

    // back-to-back throughput
    do_reset();
    step_ready = 1'b1;
    for (int k = 0; k < 10; k++) send_frame(mk_frame(32'($urandom_range(0, 3))), 1'b0);
    in_valid = 1'b0;
    drain();
    check("b2b_count", cons_cyc.size(), 10);
    for (int k = 1; k < cons_cyc.size(); k++) check("b2b_spacing", cons_cyc[k] - cons_cyc[k-1], 8);

    // reserved flag bits
    do_reset();
    step_ready = 1'b1;
    send_frame(mk_frame(32'h00000004), 1'b0);
    in_valid = 1'b0;
    drain();
    check("flag_err_set", frame_error, 1'b1);
    check("flag_frame_delivered", cons_idx.size(), 1);
    send_frame(mk_frame(32'h00000003), 1'b0);
    in_valid = 1'b0;
    drain();
    check("flag_err_sticky", frame_error, 1'b1);
    do_reset();
    @(negedge clk);
    check("flag_err_cleared", frame_error, 1'b0);
    @(posedge clk); #1;

    // mid-frame reset
    do_reset();
    step_ready = 1'b1;
    f = mk_frame(32'd0);
    for (int i = 0; i < 5; i++) send_word(f[i], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    f[0] = 32'hA0A1A2A3; f[1] = 32'hB0B1B2B3; f[2] = 32'hC0C1C2C3; f[3] = 32'd2;
    send_frame(f, 1'b0);
    in_valid = 1'b0;
    drain();
    check("midrst_count", cons_idx.size(), 1);
    if (cons_idx.size() == 1) begin
      check("midrst_idx", cons_idx[0], 32'd0);
      check("midrst_raw", cons_raw[0], 96'hC0C1C2C3_B0B1B2B3_A0A1A2A3);
    end

    // step index wrap
    do_reset();
    force dut.step_count_r = 32'hFFFFFFFF;
    preload_val = 32'hFFFFFFFF;
    preload_cnt++;
    tick();
    release dut.step_count_r;
    step_ready = 1'b1;
    send_frame(mk_frame(32'd1), 1'b0);
    send_frame(mk_frame(32'd0), 1'b0);
    in_valid = 1'b0;
    drain();
    check("wrap_count", cons_idx.size(), 2);
    if (cons_idx.size() == 2) begin
      check("wrap_idx0", cons_idx[0], 32'hFFFFFFFF);
      check("wrap_idx1", cons_idx[1], 32'h00000000);
    end

    // randomized traffic with gaps and random backpressure
    do_reset();
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) send_frame(mk_frame($urandom), 1'b1);
      else send_frame(mk_frame(32'($urandom_range(0, 3))), 1'b1);
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    drain();
    check("rand_count", cons_idx.size(), 30);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/witness_step_loader.md
WITNESS_STEP_LOADER -- requirements
Module: witness_step_loader

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 8, meaning 32-bit words per step frame; fixed at 8, and other values are unsupported.
REQ-002 SHALL have parameter STRICT_FLAGS, default 1, meaning reserved flag bits are checked.
REQ-003 SHALL have port clk, input, 1, the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream witness word is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the loader accepts a word this cycle.
REQ-007 SHALL have port in_data, input, 32, the witness word.
REQ-008 SHALL have port step_valid, output, 1, meaning an assembled step is presented to the decoder.
REQ-009 SHALL have port step_ready, input, 1, meaning the decoder/executor consumes the step.
REQ-010 SHALL have port raw_instr, output, 96, instruction bytes for the decoder.
REQ-011 SHALL have ports hint1_is_write and hint2_is_write, output, 1 each, the hint direction.
REQ-012 SHALL have ports hint1_address, hint1_data, hint2_address and hint2_data, output, 32 each, the memory hint fields.
REQ-013 SHALL have port step_index, output, 32, the count of steps handed off, captured with each step.
REQ-014 SHALL have port frame_error, output, 1, a sticky malformed-frame flag.

Function
REQ-015 SHALL define the frame word order as: w0..w2 for raw_instr, w3 for flags, w4 for hint1_address, w5 for hint1_data, w6 for hint2_address, and w7 for hint2_data.
REQ-016 SHALL place word k (k=0..2) in raw_instr[32k+31:32k], so the first instruction byte is raw_instr[7:0].
REQ-017 SHALL take hint1_is_write from flags bit0 and hint2_is_write from flags bit1; bits[31:2] are reserved.
REQ-018 SHALL transfer a word only on in_valid && in_ready.
REQ-019 SHALL transfer a step only on step_valid && step_ready.
REQ-020 SHALL implement an FSM with states COLLECT (word counter 0..7) and FULL (assembly buffer complete, output register occupied).
REQ-021 SHALL, in COLLECT, hold in_ready=1; each accepted word is written to its buffer slot and the counter increments.
REQ-022 SHALL wrap the counter 7->0 on acceptance of w7.
REQ-023 SHALL move w7 together with w0..w6 into the output register on the next edge if the output register is empty or is being consumed in that same cycle; otherwise the FSM enters FULL.
REQ-024 SHALL, in FULL, hold in_ready=0; on step_ready the buffer moves to the output register and the FSM returns to COLLECT.
REQ-025 SHALL have a latency of exactly 1 cycle from acceptance of w7 to step_valid=1 when the output is free.
REQ-026 SHALL sustain a throughput of one step per 8 cycles under continuous in_valid and step_ready.
REQ-027 SHALL hold output fields and step_valid stable while step_valid && !step_ready.
REQ-028 SHALL capture step_index as the running count on load, incrementing by 1 per load and wrapping at 2^32-1 -> 0.
REQ-029 SHALL, when STRICT_FLAGS=1 and reserved flag bits are nonzero on w3 acceptance, set frame_error to 1, which stays set until reset; the frame is still delivered.
REQ-030 SHALL handle simultaneous acceptance of w7 and output consumption with no bubble and no loss.

Reset
REQ-031 SHALL, on rst, take the FSM to COLLECT with counter 0 and set step_valid=0, step_index counter=0, and frame_error=0.
REQ-032 SHALL drive raw_instr, the hint outputs and step_index to 0 after reset.
REQ-033 SHALL, when rst asserts mid-frame, discard partial words; the next accepted word is w0.
REQ-034 SHALL drive in_ready=0 during the rst cycle.

Structure
REQ-035 SHALL place the frame word offsets (W_INSTR0..W_HINT2_DATA), FRAME_WORDS, the flag bit positions and the FSM state enum in shared package witness_pkg.
REQ-036 SHALL use one sub-module, witness_frame_buffer, holding the 8-word slot array with counter and write-enable.
REQ-037 SHALL connect the outputs port-for-port to decode's raw_instr and hint inputs.

Verification
REQ-038 SHALL verify single-frame load: words 0x11223344, 0x55667788, 0x99AABBCC, 0x00000003, 0x1000, 0xDEAD, 0x2000, 0xBEEF with step_ready=1 gives step_valid one cycle after w7, raw_instr=0x99AABBCC_55667788_11223344, both is_write=1 and step_index=0.
REQ-039 SHALL verify backpressure: hold step_ready=0 and stream 2 frames, giving in_ready=0 after the second w7 and outputs stable; releasing step_ready yields step_index 0, then 1, with no data loss.
REQ-040 SHALL verify back-to-back frames: 10 frames with continuous valid/ready give exactly 10 steps, 8 cycles apart.
REQ-041 SHALL verify the reserved flag check: flags=0x00000004 sets frame_error=1 while the frame is still delivered, and frame_error holds across later good frames until rst.
REQ-042 SHALL verify mid-frame reset: assert rst after w4, then send a full frame, which is delivered intact with step_index=0.
REQ-043 SHALL verify index wrap: preload the counter to 0xFFFFFFFF via force, and two steps read 0xFFFFFFFF then 0x00000000.
